// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared forwarding selects, EX-stage image types and helpers for id_ex_pipe
package pipe_pkg;

  localparam logic [1:0]  FWD_RF    = 2'b00;
  localparam logic [1:0]  FWD_MEM   = 2'b01;
  localparam logic [1:0]  FWD_WB    = 2'b10;
  localparam logic [31:0] NOP_ORDER = 32'h0;

  typedef struct packed {
    logic       shift;
    logic       lui;
    logic       bne;
    logic       beq;
    logic       blez;
    logic       bgtz;
    logic       bz;
    logic       jmp;
    logic       jr;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } ex_ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] order;
    logic [31:0] pc_plus_4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        use_rs;
    logic        use_rt;
    ex_ctrl_t    ctrl;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
  } ex_stage_t;

  // Bubble: sll nop with no side effects; every other field is zero.
  function automatic ex_stage_t bubble_image();
    ex_stage_t b;
    b       = '0;
    b.order = NOP_ORDER;
    return b;
  endfunction

  // The instruction now in EX reaches MEM next cycle, so it is the newer value.
  function automatic logic [1:0] fwd_select(input logic [4:0] src, input logic src_live,
                                            input logic ex_hit_en, input logic [4:0] ex_dst,
                                            input logic mem_hit_en, input logic [4:0] mem_dst);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src_live) begin
      if (ex_hit_en && (src == ex_dst))
        sel = FWD_MEM;
      else if (mem_hit_en && (src == mem_dst))
        sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - decode-side instruction bundle and registered EX-side copy
interface id_ex_pipe_if;

  logic        id_valid;
  logic [31:0] id_order;
  logic [31:0] id_pc_plus_4;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dst;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_shift;
  logic        id_lui;
  logic        id_bne;
  logic        id_beq;
  logic        id_blez;
  logic        id_bgtz;
  logic        id_bz;
  logic        id_jmp;
  logic        id_jr;
  logic [3:0]  id_alu_op;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;

  logic        ex_valid;
  logic [31:0] ex_order;
  logic [31:0] ex_pc_plus_4;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dst;
  logic        ex_use_rs;
  logic        ex_use_rt;
  logic        ex_shift;
  logic        ex_lui;
  logic        ex_bne;
  logic        ex_beq;
  logic        ex_blez;
  logic        ex_bgtz;
  logic        ex_bz;
  logic        ex_jmp;
  logic        ex_jr;
  logic [3:0]  ex_alu_op;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [1:0]  ex_sel_a;
  logic [1:0]  ex_sel_b;

  modport master (
    output id_valid, id_order, id_pc_plus_4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_dst,
           id_use_rs, id_use_rt, id_shift, id_lui, id_bne, id_beq, id_blez, id_bgtz, id_bz,
           id_jmp, id_jr, id_alu_op, id_mem_read, id_mem_write, id_reg_write,
    input  ex_valid, ex_order, ex_pc_plus_4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_dst,
           ex_use_rs, ex_use_rt, ex_shift, ex_lui, ex_bne, ex_beq, ex_blez, ex_bgtz, ex_bz,
           ex_jmp, ex_jr, ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write, ex_sel_a, ex_sel_b
  );

  modport slave (
    input  id_valid, id_order, id_pc_plus_4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_dst,
           id_use_rs, id_use_rt, id_shift, id_lui, id_bne, id_beq, id_blez, id_bgtz, id_bz,
           id_jmp, id_jr, id_alu_op, id_mem_read, id_mem_write, id_reg_write,
    output ex_valid, ex_order, ex_pc_plus_4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_dst,
           ex_use_rs, ex_use_rt, ex_shift, ex_lui, ex_bne, ex_beq, ex_blez, ex_bgtz, ex_bz,
           ex_jmp, ex_jr, ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write, ex_sel_a, ex_sel_b
  );

endinterface

// File: rtl/id_ex_pipe_hazard_unit.sv
// rtl/id_ex_pipe_hazard_unit.sv - module hazard_unit: combinational load-use detect and forwarding-select compare
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_dst,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_dst,
  output logic       load_use,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b
);

  // Register 0 is hard-wired zero and numbers past NREG-1 name no real register.
  localparam logic [4:0] MAX_REG = 5'(NREG - 1);

  logic rs_live;
  logic rt_live;
  logic ex_load_live;

  assign rs_live      = id_use_rs && (id_rs != 5'd0) && (id_rs <= MAX_REG);
  assign rt_live      = id_use_rt && (id_rt != 5'd0) && (id_rt <= MAX_REG);
  assign ex_load_live = ex_valid && ex_mem_read && (ex_dst != 5'd0);

  assign load_use = id_valid && ex_load_live &&
                    ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));

  assign sel_a = fwd_select(id_rs, rs_live, ex_valid && ex_reg_write, ex_dst,
                            mem_reg_write, mem_dst);
  assign sel_b = fwd_select(id_rt, rt_live, ex_valid && ex_reg_write, ex_dst,
                            mem_reg_write, mem_dst);

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX register with load-use stall, flush and forwarding selects
// Optional hazard counters: ID_EX_HAZARD_STATS_EN
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_pipe_if.slave       pif,
  input  logic              ex_branch,
  input  logic              int_request,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_dst,
  output logic              stall,
  output logic              id_flush
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);

  ex_stage_t  ex_q;
  ex_stage_t  ex_d;
  logic       load_use;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_bubble;

  hazard_unit #(.NREG(NREG)) u_hazard (
    .id_valid      (pif.id_valid),
    .id_rs         (pif.id_rs),
    .id_rt         (pif.id_rt),
    .id_use_rs     (pif.id_use_rs),
    .id_use_rt     (pif.id_use_rt),
    .ex_valid      (ex_q.valid),
    .ex_mem_read   (ex_q.ctrl.mem_read),
    .ex_reg_write  (ex_q.ctrl.reg_write),
    .ex_dst        (ex_q.dst),
    .mem_reg_write (mem_reg_write),
    .mem_dst       (mem_dst),
    .load_use      (load_use),
    .sel_a         (sel_a),
    .sel_b         (sel_b)
  );

  assign id_flush = ex_branch | int_request;
  assign stall    = load_use & ~id_flush;

  // An empty decode slot travels as a bubble so EX never sees stale fields.
  assign load_bubble = id_flush | stall | ~pif.id_valid;

  always_comb begin
    ex_d                = '0;
    ex_d.valid          = pif.id_valid;
    ex_d.order          = pif.id_order;
    ex_d.pc_plus_4      = pif.id_pc_plus_4;
    ex_d.rd1            = pif.id_rd1;
    ex_d.rd2            = pif.id_rd2;
    ex_d.imm            = pif.id_imm;
    ex_d.rs             = pif.id_rs;
    ex_d.rt             = pif.id_rt;
    ex_d.dst            = pif.id_dst;
    ex_d.use_rs         = pif.id_use_rs;
    ex_d.use_rt         = pif.id_use_rt;
    ex_d.ctrl.shift     = pif.id_shift;
    ex_d.ctrl.lui       = pif.id_lui;
    ex_d.ctrl.bne       = pif.id_bne;
    ex_d.ctrl.beq       = pif.id_beq;
    ex_d.ctrl.blez      = pif.id_blez;
    ex_d.ctrl.bgtz      = pif.id_bgtz;
    ex_d.ctrl.bz        = pif.id_bz;
    ex_d.ctrl.jmp       = pif.id_jmp;
    ex_d.ctrl.jr        = pif.id_jr;
    ex_d.ctrl.alu_op    = pif.id_alu_op;
    ex_d.ctrl.mem_read  = pif.id_mem_read;
    ex_d.ctrl.mem_write = pif.id_mem_write;
    ex_d.ctrl.reg_write = pif.id_reg_write;
    ex_d.sel_a          = sel_a;
    ex_d.sel_b          = sel_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ex_q <= '0;
    else if (load_bubble)
      ex_q <= bubble_image();
    else
      ex_q <= ex_d;
  end

  assign pif.ex_valid     = ex_q.valid;
  assign pif.ex_order     = ex_q.order;
  assign pif.ex_pc_plus_4 = ex_q.pc_plus_4;
  assign pif.ex_rd1       = ex_q.rd1;
  assign pif.ex_rd2       = ex_q.rd2;
  assign pif.ex_imm       = ex_q.imm;
  assign pif.ex_rs        = ex_q.rs;
  assign pif.ex_rt        = ex_q.rt;
  assign pif.ex_dst       = ex_q.dst;
  assign pif.ex_use_rs    = ex_q.use_rs;
  assign pif.ex_use_rt    = ex_q.use_rt;
  assign pif.ex_shift     = ex_q.ctrl.shift;
  assign pif.ex_lui       = ex_q.ctrl.lui;
  assign pif.ex_bne       = ex_q.ctrl.bne;
  assign pif.ex_beq       = ex_q.ctrl.beq;
  assign pif.ex_blez      = ex_q.ctrl.blez;
  assign pif.ex_bgtz      = ex_q.ctrl.bgtz;
  assign pif.ex_bz        = ex_q.ctrl.bz;
  assign pif.ex_jmp       = ex_q.ctrl.jmp;
  assign pif.ex_jr        = ex_q.ctrl.jr;
  assign pif.ex_alu_op    = ex_q.ctrl.alu_op;
  assign pif.ex_mem_read  = ex_q.ctrl.mem_read;
  assign pif.ex_mem_write = ex_q.ctrl.mem_write;
  assign pif.ex_reg_write = ex_q.ctrl.reg_write;
  assign pif.ex_sel_a     = ex_q.sel_a;
  assign pif.ex_sel_b     = ex_q.sel_b;

`ifdef ID_EX_HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
      if (id_flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed self-checking bench for id_ex_pipe (honours ID_EX_HAZARD_STATS_EN)
module tb_id_ex_pipe;

  logic        clk;
  logic        rst_n;
  logic        ex_branch;
  logic        int_request;
  logic        mem_reg_write;
  logic [4:0]  mem_dst;
  logic        stall;
  logic        id_flush;
`ifdef ID_EX_HAZARD_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  int          n_checks;
  int          n_fail;
  logic [31:0] pc;

  id_ex_pipe_if bus ();

  id_ex_pipe #(.NREG(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pif           (bus.slave),
    .ex_branch     (ex_branch),
    .int_request   (int_request),
    .mem_reg_write (mem_reg_write),
    .mem_dst       (mem_dst),
    .stall         (stall),
    .id_flush      (id_flush)
`ifdef ID_EX_HAZARD_STATS_EN
    ,
    .stall_count   (stall_count),
    .flush_count   (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] order, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] dst, input logic use_rs, input logic use_rt,
                           input logic mem_read, input logic reg_write);
    pc                = pc + 32'd4;
    bus.id_valid      = 1'b1;
    bus.id_order      = order;
    bus.id_pc_plus_4  = pc;
    bus.id_rd1        = 32'h0000_1000 + 32'(rs);
    bus.id_rd2        = 32'h0000_2000 + 32'(rt);
    bus.id_imm        = {16'h0, order[15:0]};
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_dst        = dst;
    bus.id_use_rs     = use_rs;
    bus.id_use_rt     = use_rt;
    bus.id_shift      = 1'b0;
    bus.id_lui        = 1'b0;
    bus.id_bne        = 1'b0;
    bus.id_beq        = 1'b0;
    bus.id_blez       = 1'b0;
    bus.id_bgtz       = 1'b0;
    bus.id_bz         = 1'b0;
    bus.id_jmp        = 1'b0;
    bus.id_jr         = 1'b0;
    bus.id_alu_op     = 4'h2;
    bus.id_mem_read   = mem_read;
    bus.id_mem_write  = 1'b0;
    bus.id_reg_write  = reg_write;
  endtask

  task automatic randomize_id();
    bus.id_valid     = 1'b1;
    bus.id_order     = $urandom;
    bus.id_pc_plus_4 = $urandom;
    bus.id_rd1       = $urandom;
    bus.id_rd2       = $urandom;
    bus.id_imm       = $urandom;
    bus.id_rs        = 5'($urandom_range(31));
    bus.id_rt        = 5'($urandom_range(31));
    bus.id_dst       = 5'($urandom_range(31));
    bus.id_use_rs    = 1'($urandom_range(1));
    bus.id_use_rt    = 1'($urandom_range(1));
    bus.id_shift     = 1'($urandom_range(1));
    bus.id_lui       = 1'($urandom_range(1));
    bus.id_bne       = 1'($urandom_range(1));
    bus.id_beq       = 1'($urandom_range(1));
    bus.id_blez      = 1'($urandom_range(1));
    bus.id_bgtz      = 1'($urandom_range(1));
    bus.id_bz        = 1'($urandom_range(1));
    bus.id_jmp       = 1'($urandom_range(1));
    bus.id_jr        = 1'($urandom_range(1));
    bus.id_alu_op    = 4'($urandom_range(15));
    bus.id_mem_read  = 1'b1;
    bus.id_mem_write = 1'($urandom_range(1));
    bus.id_reg_write = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    pc            = 32'h0040_0000;
    rst_n         = 1'b0;
    ex_branch     = 1'b0;
    int_request   = 1'b0;
    mem_reg_write = 1'b0;
    mem_dst       = 5'd0;
    randomize_id();

    // Reset with random decode inputs
    step();
    randomize_id();
    step();
    check_val("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check_val("rst_ex_order", bus.ex_order, 32'd0);
    check_val("rst_ex_mem_read", 32'(bus.ex_mem_read), 32'd0);
    check_val("rst_ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
    check_val("rst_sel", {28'd0, bus.ex_sel_a, bus.ex_sel_b}, 32'd0);
    bus.id_valid = 1'b0;
    rst_n        = 1'b1;
    step();
    check_val("rel_ex_valid", 32'(bus.ex_valid), 32'd0);
    check_val("rel_ex_order", bus.ex_order, 32'd0);
    check_val("rel_ex_rd1", bus.ex_rd1, 32'd0);
    check_val("rel_sel", {28'd0, bus.ex_sel_a, bus.ex_sel_b}, 32'd0);

    // add $3,$1,$2 then sub $4,$3,$5: EX-to-MEM forward on rs
    set_instr(32'h0022_1820, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check_val("add_ex_valid", 32'(bus.ex_valid), 32'd1);
    check_val("add_ex_dst", 32'(bus.ex_dst), 32'd3);
    check_val("add_ex_order", bus.ex_order, 32'h0022_1820);
    check_val("add_ex_pc", bus.ex_pc_plus_4, pc);
    check_val("add_ex_rd1", bus.ex_rd1, 32'h0000_1001);
    check_val("add_ex_imm", bus.ex_imm, 32'h0000_1820);
    set_instr(32'h0065_2022, 5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check_val("sub_stall", 32'(stall), 32'd0);
    step();
    check_val("sub_sel_a", 32'(bus.ex_sel_a), 32'(2'b01));
    check_val("sub_sel_b", 32'(bus.ex_sel_b), 32'(2'b00));

    // add $3, nop, or $6,$7,$3: WB forward on rt
    set_instr(32'h0022_1820, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_instr(32'h0000_0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_instr(32'h00E3_3025, 5'd7, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    mem_reg_write = 1'b1;
    mem_dst       = 5'd3;
    step();
    check_val("or_wb_sel_a", 32'(bus.ex_sel_a), 32'(2'b00));
    check_val("or_wb_sel_b", 32'(bus.ex_sel_b), 32'(2'b10));
    mem_reg_write = 1'b0;

    // add $3, add $3, or ...$3: the newer (MEM) value wins
    set_instr(32'h0022_1820, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_instr(32'h0022_1820, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_instr(32'h00E3_3025, 5'd7, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    mem_reg_write = 1'b1;
    mem_dst       = 5'd3;
    step();
    check_val("or_pri_sel_b", 32'(bus.ex_sel_b), 32'(2'b01));
    mem_reg_write = 1'b0;

    // lw $5,0($1) then add $6,$5,$5: one stall, bubble, then WB forward on both
    set_instr(32'h8C25_0000, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_instr(32'h00A5_3020, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check_val("lu_stall", 32'(stall), 32'd1);
    check_val("lu_flush", 32'(id_flush), 32'd0);
    step();
    check_val("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    check_val("lu_bubble_mem_read", 32'(bus.ex_mem_read), 32'd0);
    check_val("lu_stall_clear", 32'(stall), 32'd0);
    mem_reg_write = 1'b1;
    mem_dst       = 5'd5;
    step();
    check_val("lu_add_valid", 32'(bus.ex_valid), 32'd1);
    check_val("lu_add_dst", 32'(bus.ex_dst), 32'd6);
    check_val("lu_add_sel_a", 32'(bus.ex_sel_a), 32'(2'b10));
    check_val("lu_add_sel_b", 32'(bus.ex_sel_b), 32'(2'b10));
`ifdef ID_EX_HAZARD_STATS_EN
    check_val("stall_count_1", stall_count, 32'd1);
`endif
    mem_reg_write = 1'b0;

    // load-use coincident with a taken branch: flush wins
    set_instr(32'h8C25_0000, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_instr(32'h00A5_3020, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    ex_branch = 1'b1;
    #1;
    check_val("br_stall", 32'(stall), 32'd0);
    check_val("br_flush", 32'(id_flush), 32'd1);
    step();
    ex_branch = 1'b0;
    check_val("br_bubble_valid", 32'(bus.ex_valid), 32'd0);
    check_val("br_bubble_order", bus.ex_order, 32'd0);

    // same with an interrupt redirect
    set_instr(32'h8C25_0000, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_instr(32'h00A5_3020, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    int_request = 1'b1;
    #1;
    check_val("int_stall", 32'(stall), 32'd0);
    check_val("int_flush", 32'(id_flush), 32'd1);
    step();
    int_request = 1'b0;
    check_val("int_bubble_valid", 32'(bus.ex_valid), 32'd0);
    check_val("int_bubble_reg_write", 32'(bus.ex_reg_write), 32'd0);
`ifdef ID_EX_HAZARD_STATS_EN
    check_val("flush_count_2", flush_count, 32'd2);
    check_val("stall_count_still_1", stall_count, 32'd1);
`endif

    // $0 is never forwarded and never causes a load-use stall
    set_instr(32'h2020_0005, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    set_instr(32'h0000_3825, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    mem_reg_write = 1'b1;
    mem_dst       = 5'd0;
    step();
    check_val("r0_sel", {28'd0, bus.ex_sel_a, bus.ex_sel_b}, 32'd0);
    mem_reg_write = 1'b0;
    set_instr(32'h8C20_0000, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_instr(32'h0000_3825, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check_val("r0_lw_stall", 32'(stall), 32'd0);
    step();
    check_val("r0_lw_capture", 32'(bus.ex_valid), 32'd1);

    // asynchronous reset mid-stream, then normal capture
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
    check_val("mid_rst_order", bus.ex_order, 32'd0);
`ifdef ID_EX_HAZARD_STATS_EN
    check_val("mid_rst_stall_count", stall_count, 32'd0);
`endif
    rst_n = 1'b1;
    set_instr(32'h0022_1820, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check_val("post_rst_valid", 32'(bus.ex_valid), 32'd1);
    check_val("post_rst_order", bus.ex_order, 32'h0022_1820);
    check_val("post_rst_sel", {28'd0, bus.ex_sel_a, bus.ex_sel_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register with integrated hazard control for the 5-stage MIPS pipeline. It sits between the decode stage and the EX stage and captures operands, immediate, PC+4 and all decode control for EX. It generates the registered `Sel_A`/`Sel_B` forwarding selects that EX uses to pick RD1/RD2, MEM_ALU_result or WB_RegFile_Din. It also detects load-use hazards (stall + bubble) and squashes the decode-stage instruction on a taken branch/jump or interrupt.

## Interface
Parameters:
- `NREG`, default 32: architectural register count. Register 0 is hard-wired zero and is never forwarded.

Ports:
- `clk`  in  1  rising-edge clock; the single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode holds a real instruction.
- `id_order`, `id_pc_plus_4`, `id_rd1`, `id_rd2`, `id_imm`  in  32 each  decode-stage instruction word, PC+4, register reads and sign-extended immediate.
- `id_rs`, `id_rt`, `id_dst`  in  5 each  source and destination register numbers.
- `id_use_rs`, `id_use_rt`  in  1 each  instruction actually reads rs/rt.
- `id_shift`, `id_lui`, `id_bne`, `id_beq`, `id_blez`, `id_bgtz`, `id_bz`, `id_jmp`, `id_jr`  in  1 each  EX control.
- `id_alu_op`  in  4  ALU operation.
- `id_mem_read`, `id_mem_write`, `id_reg_write`  in  1 each  later-stage control.
- `ex_branch`  in  1  EX resolved a taken branch/jump this cycle.
- `int_request`  in  1  interrupt redirect this cycle.
- `mem_reg_write`  in  1  instruction currently in MEM writes the register file.
- `mem_dst`  in  5  destination register of that MEM instruction.
- `ex_*`  out  same widths as `id_*`  registered copies of all of the above, including `ex_valid`, `ex_dst`, `ex_mem_read`, `ex_reg_write`.
- `ex_sel_a`, `ex_sel_b`  out  2 each  forwarding selects: 00 regfile, 01 MEM, 10 WB.
- `stall`  out  1  combinational; IF and the IF/ID register hold.
- `id_flush`  out  1  combinational; IF/ID register loads a bubble.

## Operation
- Every output register resets to 0, and `ex_sel_*` resets to 00. A bubble uses the same all-zero image: order 0 (sll nop), no writes, no branches, `ex_valid`=0.
- Load-use condition, `lu`:
  - `ex_valid & ex_mem_read & ex_dst!=0`, and
  - (`id_use_rs & id_rs==ex_dst`) or (`id_use_rt & id_rt==ex_dst`), and
  - `id_valid`.
- `id_flush = ex_branch | int_request`.
- `stall = lu & ~id_flush`.
- Next-state priority:
  1. flush → bubble.
  2. stall → bubble, and ID is held by upstream.
  3. otherwise → capture the `id_*` inputs.
- Forwarding, computed at capture for each source independently (rs→`ex_sel_a`, rt→`ex_sel_b`):
  - `src!=0 & ex_valid & ex_reg_write & src==ex_dst` → 01. The current EX instruction becomes MEM.
  - else `src!=0 & mem_reg_write & src==mem_dst` → 10. The current MEM instruction becomes WB.
  - else → 00.
  - The MEM match has priority over the WB match, since it is the newer value.
  - When the corresponding `id_use_*` is 0, the select is forced to 00.
- After a one-cycle load-use stall the load is in MEM, so the dependent instruction captures select 10 and receives the load data via WB_RegFile_Din. One stall cycle is always sufficient.

## Timing
- Latency: 1 cycle, ID inputs to `ex_*`.
- `stall` and `id_flush` are combinational from the `id_*` inputs and the current `ex_*` registers. There is no combinational path from any `id_*` input to any `ex_*` output.
- A stall lasts exactly one cycle per load-use pair; the bubble clears `ex_mem_read`.
- Simultaneous flush and load-use: flush wins, and `stall`=0.
- Reset asserted mid-operation clears all registers immediately. The first instruction after release is captured normally.

## Configuration
- `ID_EX_HAZARD_STATS_EN`
  - Defined: adds output ports `stall_count` and `flush_count`, each 32 bits. They increment on cycles with `stall`=1 or `id_flush`=1 respectively, saturate at 0xFFFFFFFF, and reset to 0.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - select constants `FWD_RF`=2'b00, `FWD_MEM`=2'b01, `FWD_WB`=2'b10;
  - the EX control struct typedef;
  - `NOP_ORDER`=32'h0.
- Sub-module `hazard_unit`: the combinational load-use detection and forwarding-select compare. It is instantiated once; the register bank stays in `id_ex_pipe`.

## Test plan
- Reset with random `id_*` inputs → all `ex_*` are 0 and `ex_sel_*` are 00 while `rst_n`=0 and on the first edge after release with `id_valid`=0.
- `add $3,$1,$2`, then `sub $4,$3,$5` → the sub captures `ex_sel_a`=01, `ex_sel_b`=00.
- `add $3`, `nop`, `or $6,$7,$3` → the or captures `ex_sel_b`=10. For `add $3`, `add $3`, `or …$3` → `ex_sel_b`=01 (MEM priority).
- `lw $5,0($1)`, then `add $6,$5,$5`:
  - first cycle: `stall`=1 for one cycle and EX gets a bubble;
  - next cycle: the add is captured with `ex_sel_a`=`ex_sel_b`=10.
- Load-use pair present with `ex_branch`=1 in the same cycle → `stall`=0, `id_flush`=1, EX gets a bubble. Repeat with `int_request`=1 for the same result.
- Writer `addi $0`, then a reader of `$0` → selects stay 00. With `ID_EX_HAZARD_STATS_EN` defined, the load-use test ends with `stall_count`=1.
